pixel_word_loader: RTL

//  Upstream feeder for the register bank. Accepts a byte stream of pixel data
//  (valid/ready), packs WORD_BYTES bytes into one word, and issues one-cycle

---
 rtl/pwl_pkg.sv | 18 +
 rtl/pwl_byte_packer.sv | 50 +++++
 rtl/pixel_word_loader.sv | 130 +++++++++++++
 3 files changed

// File: rtl/pwl_pkg.sv
// Shared definitions for the pixel word loader: FSM encoding, byte width and
// the counter-width helper used by the packer and the stall counter.
package pwl_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_WRITE   = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pwl_byte_packer.sv
// Byte packer: inserts accepted bytes little-endian into the word register and
// flags the byte that completes a word. clear_i discards a partial word.
module pwl_byte_packer
  import pwl_pkg::*;
#(
  parameter int WORD_BYTES = 4,
  localparam int CNT_W = cnt_width(WORD_BYTES)
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         clear_i,
  input  logic                         load_i,
  input  logic [BYTE_W-1:0]            data_i,
  output logic [BYTE_W*WORD_BYTES-1:0] word_o,
  output logic [CNT_W-1:0]             byte_cnt_o,
  output logic                         word_full_o
);

  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic [BYTE_W*WORD_BYTES-1:0] word_q, word_d;

  assign word_full_o = load_i && (cnt_q == CNT_W'(WORD_BYTES - 1));

  always_comb begin
    cnt_d  = cnt_q;
    word_d = word_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = word_full_o ? '0 : cnt_q + 1'b1;
      for (int k = 0; k < WORD_BYTES; k++) begin
        if (cnt_q == CNT_W'(k)) word_d[k*BYTE_W +: BYTE_W] = data_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      word_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      word_q <= word_d;
    end
  end

  assign word_o     = word_q;
  assign byte_cnt_o = cnt_q;

endmodule

// File: rtl/pixel_word_loader.sv
// Pixel word loader: packs a byte stream into words and strobes them into the
// register bank. Optional stall timeout enabled by defining PWL_TIMEOUT_EN.
module pixel_word_loader
  import pwl_pkg::*;
#(
  parameter int WORD_BYTES     = 4,
  parameter int NUM_WORDS      = 196,
  parameter int ADDR_BITS      = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         start_i,
  input  logic                         abort_i,
  input  logic [BYTE_W-1:0]            in_data_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  output logic [BYTE_W*WORD_BYTES-1:0] reg_d_o,
  output logic                         reg_ce_o,
  output logic [ADDR_BITS-1:0]         reg_addr_o,
  output logic                         busy_o,
  output logic                         frame_done_o,
  output logic                         timeout_err_o
);

  localparam int CNT_W = cnt_width(WORD_BYTES);
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(NUM_WORDS - 1);

  state_e                 state_q, state_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic                   pk_clear, pk_load, word_full, drop_word;
  logic [CNT_W-1:0]       byte_cnt;

  pwl_byte_packer #(.WORD_BYTES(WORD_BYTES)) u_packer (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clear_i     (pk_clear),
    .load_i      (pk_load),
    .data_i      (in_data_i),
    .word_o      (reg_d_o),
    .byte_cnt_o  (byte_cnt),
    .word_full_o (word_full)
  );

`ifdef PWL_TIMEOUT_EN
  localparam int STALL_W = cnt_width(TIMEOUT_CYCLES);
  logic [STALL_W-1:0] stall_q, stall_d;

  // Stall counting only while a partial word is pending and no byte arrives.
  always_comb begin
    stall_d   = '0;
    drop_word = 1'b0;
    if (state_q == ST_COLLECT && !abort_i && byte_cnt != '0 && !in_valid_i) begin
      if (stall_q == STALL_W'(TIMEOUT_CYCLES - 1)) drop_word = 1'b1;
      else                                         stall_d   = stall_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) stall_q <= '0;
    else         stall_q <= stall_d;
  end

  assign timeout_err_o = drop_word;
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
  logic unused_cnt;
  assign unused_cnt    = ^byte_cnt;
  assign drop_word     = 1'b0;
  assign timeout_err_o = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    pk_clear   = 1'b0;
    pk_load    = 1'b0;
    in_ready_o = 1'b0;
    reg_ce_o   = 1'b0;
    if (abort_i) begin
      state_d  = ST_IDLE;
      pk_clear = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_i) begin
            state_d  = ST_COLLECT;
            addr_d   = '0;
            pk_clear = 1'b1;
          end
        end
        ST_COLLECT: begin
          in_ready_o = 1'b1;
          if (in_valid_i) begin
            pk_load = 1'b1;
            if (word_full) state_d = ST_WRITE;
          end else if (drop_word) begin
            pk_clear = 1'b1;
          end
        end
        ST_WRITE: begin
          reg_ce_o = 1'b1;
          if (addr_q == LAST_ADDR) begin
            state_d = ST_DONE;
          end else begin
            state_d  = ST_COLLECT;
            addr_d   = addr_q + 1'b1;
            pk_clear = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  assign reg_addr_o   = addr_q;
  assign busy_o       = (state_q == ST_COLLECT) || (state_q == ST_WRITE);
  assign frame_done_o = (state_q == ST_DONE);

endmodule
